// File: rtl/cac_wrbk.sv
// Cache-to-memory writeback transmitter: reads one cache line into a local buffer,
// checks parity, then streams it out word by word. Optional: CAC_WB_PAR_REGEN_EN.
module cac_wrbk #(
    parameter int DATA_W     = 36,
    parameter int LINE_ADR_W = 7,
    parameter int WORDS      = 4
) (
    input  logic                    clk_h,
    input  logic                    reset_l,
    input  logic                    wb_req_h,
    input  logic [LINE_ADR_W+1:0]   wb_adr_h,
    output logic                    wb_busy_h,
    output logic                    wb_done_h,
    output logic                    csh_rd_en_h,
    output logic [LINE_ADR_W+1:0]   csh_rd_adr_h,
    input  logic [DATA_W-1:0]       cache_data_h,
    input  logic                    csh_par_bit_h,
    output logic [DATA_W-1:0]       cache_to_mem_h,
    output logic                    cache_to_mem_par_h,
    output logic [LINE_ADR_W+1:0]   mem_wr_adr_h,
    output logic                    mem_wr_rq_h,
    input  logic                    mem_ack_h,
    output logic                    wb_par_err_h
);

    localparam int WSEL_W = $clog2(WORDS);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_XMIT,
        ST_DONE
    } state_t;

    state_t                  state_reg, state_next;
    logic [LINE_ADR_W-1:0]   line_reg;
    logic [WSEL_W-1:0]       start_reg;
    logic [WSEL_W:0]         rd_cnt_reg, rd_cnt_next;
    logic [WSEL_W-1:0]       wd_cnt_reg, wd_cnt_next;
    logic                    cap_vld_reg;
    logic [WSEL_W-1:0]       cap_idx_reg;
    logic                    par_err_reg;
    logic [DATA_W-1:0]       data_buf_reg [WORDS];
    logic                    par_buf_reg  [WORDS];

    logic                    accept;
    logic                    rd_en;
    logic                    xmit_rq;
    logic                    done;
    logic                    cap_bad;
    logic [WSEL_W-1:0]       rd_wsel;
    logic [WSEL_W-1:0]       wr_wsel;

    // Word select wraps within the line; no carry into the line field.
    assign rd_wsel = start_reg + rd_cnt_reg[WSEL_W-1:0];
    assign wr_wsel = start_reg + wd_cnt_reg;

    // Odd parity expected over data plus stored bit.
    assign cap_bad = ~^{cache_data_h, csh_par_bit_h};

    always_ff @(posedge clk_h or negedge reset_l) begin
        if (!reset_l) begin
            state_reg  <= ST_IDLE;
            rd_cnt_reg <= '0;
            wd_cnt_reg <= '0;
        end else begin
            state_reg  <= state_next;
            rd_cnt_reg <= rd_cnt_next;
            wd_cnt_reg <= wd_cnt_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        rd_cnt_next = rd_cnt_reg;
        wd_cnt_next = wd_cnt_reg;
        accept      = 1'b0;
        rd_en       = 1'b0;
        xmit_rq     = 1'b0;
        done        = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (wb_req_h) begin
                    accept      = 1'b1;
                    rd_cnt_next = '0;
                    wd_cnt_next = '0;
                    state_next  = ST_READ;
                end
            end
            ST_READ: begin
                // Top counter bit marks the extra cycle that lets the last read land.
                if (!rd_cnt_reg[WSEL_W]) begin
                    rd_en       = 1'b1;
                    rd_cnt_next = rd_cnt_reg + 1'b1;
                end else begin
                    state_next  = ST_XMIT;
                end
            end
            ST_XMIT: begin
                xmit_rq = 1'b1;
                if (mem_ack_h) begin
                    wd_cnt_next = wd_cnt_reg + 1'b1;
                    if (wd_cnt_reg == WSEL_W'(WORDS - 1)) begin
                        state_next = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_h or negedge reset_l) begin
        if (!reset_l) begin
            line_reg    <= '0;
            start_reg   <= '0;
            cap_vld_reg <= 1'b0;
            cap_idx_reg <= '0;
            par_err_reg <= 1'b0;
        end else begin
            cap_vld_reg <= rd_en;
            cap_idx_reg <= rd_cnt_reg[WSEL_W-1:0];
            if (accept) begin
                line_reg    <= wb_adr_h[LINE_ADR_W+1:WSEL_W];
                start_reg   <= wb_adr_h[WSEL_W-1:0];
                par_err_reg <= 1'b0;
            end else if (cap_vld_reg && cap_bad) begin
                par_err_reg <= 1'b1;
            end
        end
    end

    // Line buffer; slot k always holds the k-th word in transmit order.
    generate
        for (genvar gi = 0; gi < WORDS; gi++) begin : g_slot
            always_ff @(posedge clk_h or negedge reset_l) begin
                if (!reset_l) begin
                    data_buf_reg[gi] <= '0;
                    par_buf_reg[gi]  <= 1'b0;
                end else if (cap_vld_reg && (cap_idx_reg == WSEL_W'(gi))) begin
                    data_buf_reg[gi] <= cache_data_h;
                    par_buf_reg[gi]  <= csh_par_bit_h;
                end
            end
        end
    endgenerate

    assign wb_busy_h    = (state_reg != ST_IDLE);
    assign wb_done_h    = done;
    assign wb_par_err_h = par_err_reg;

    assign csh_rd_en_h  = rd_en;
    assign csh_rd_adr_h = rd_en ? {line_reg, rd_wsel} : '0;

    assign mem_wr_rq_h    = xmit_rq;
    assign mem_wr_adr_h   = xmit_rq ? {line_reg, wr_wsel} : '0;
    assign cache_to_mem_h = xmit_rq ? data_buf_reg[wd_cnt_reg] : '0;

`ifdef CAC_WB_PAR_REGEN_EN
    // Outgoing parity rebuilt from data so a bad stored bit is not propagated.
    assign cache_to_mem_par_h = xmit_rq ? ~^data_buf_reg[wd_cnt_reg] : 1'b0;
`else
    assign cache_to_mem_par_h = xmit_rq ? par_buf_reg[wd_cnt_reg] : 1'b0;
`endif

endmodule

// File: doc/cac_wrbk.md
Name: cac_wrbk

Overview:
Cache-to-memory writeback transmitter, the outbound counterpart of the cache data slices that are loaded from mem_to_cache.
- On request, reads one 4-word cache line through the cache read port and buffers it with its parity.
- Sends the words to memory one at a time over a request/acknowledge handshake.
- Sits between the cache data slices and the memory bus interface; checks parity on every word read.

Parameters:
DATA_W, 36, cache word width (bits 00-35)
LINE_ADR_W, 7, line address width (cache_adr 27-33)
WORDS, 4, words per line; fixed power of two, word select = cache_adr 34-35

Ports:
clk_h  in  1  clock, all state on rising edge
reset_l  in  1  asynchronous active-low reset
wb_req_h  in  1  start writeback; sampled only in IDLE
wb_adr_h  in  LINE_ADR_W+2  line address plus starting word (low 2 bits)
wb_busy_h  out  1  high from accept until DONE exits
wb_done_h  out  1  one-cycle pulse after last word acknowledged
csh_rd_en_h  out  1  cache read strobe
csh_rd_adr_h  out  LINE_ADR_W+2  cache read address
cache_data_h  in  DATA_W  cache read data, valid 1 cycle after csh_rd_en_h
csh_par_bit_h  in  1  stored parity bit, same timing as cache_data_h
cache_to_mem_h  out  DATA_W  outgoing word
cache_to_mem_par_h  out  1  outgoing parity
mem_wr_adr_h  out  LINE_ADR_W+2  address of the current outgoing word
mem_wr_rq_h  out  1  word valid / write request
mem_ack_h  in  1  memory accepted current word
wb_par_err_h  out  1  sticky parity error flag

Behaviour:
- Reset (async, reset_l low): state IDLE. All outputs 0. Buffer, counters and wb_par_err_h cleared. Asserting reset mid-transfer aborts at once; no further rq.
- States: IDLE, READ, XMIT, DONE.
- IDLE:
  - wb_req_h=1 latches wb_adr_h, clears wb_par_err_h, goes to READ, and sets wb_busy_h next cycle.
  - wb_req_h is ignored in every other state.
- READ: exactly WORDS cycles with csh_rd_en_h=1.
  - Read k (k=0..3) uses address {line, (start+k) mod 4}, so word order wraps.
  - Data and parity for read k are captured one cycle later into buffer slot k.
  - After the last read, the FSM waits one cycle for the final capture, then enters XMIT. First mem_wr_rq_h is seen 6 cycles after wb_req_h is accepted.
- Parity check: odd parity over the 36 data bits plus csh_par_bit_h. Total even on any captured word sets wb_par_err_h. The flag holds until the next accepted wb_req_h; the transfer still completes.
- XMIT:
  - mem_wr_rq_h=1 with slot k on cache_to_mem_h/par and mem_wr_adr_h = {line, (start+k) mod 4}.
  - Outputs are held stable until a cycle with mem_ack_h=1.
  - On ack, the next slot is presented the following cycle with rq kept high, so back-to-back acks give 1 word per cycle.
  - mem_ack_h while mem_wr_rq_h=0 is ignored.
- After the 4th ack: mem_wr_rq_h drops, state DONE. DONE lasts one cycle with wb_done_h=1, then IDLE with wb_busy_h=0 the same cycle.
- Widths: word counter 2 bits, wraps mod 4. Address low bits are computed mod 4 with no carry into the line field.

Optional Feature:
CAC_WB_PAR_REGEN_EN
- Defined: cache_to_mem_par_h is recomputed as odd parity of the buffered data, so a corrupted stored bit goes out corrected. wb_par_err_h still reports it.
- Undefined: the stored csh_par_bit_h is passed through unchanged.

Test Plan:
- wb_adr_h line 0x15, start 0; data 0..3 with good parity; ack held high -> csh_rd_adr_h 0x54,0x55,0x56,0x57; rq 4 consecutive cycles; words 0..3; wb_done_h pulse; wb_par_err_h=0.
- Start word 2 -> reads and mem_wr_adr_h low bits ordered 2,3,0,1; data order matches.
- Ack delayed 3 cycles per word -> cache_to_mem_h/mem_wr_adr_h stable while rq high; exactly 4 words sent; spurious ack in IDLE ignored.
- Word 1 with flipped parity bit -> wb_par_err_h=1 from the capture cycle; all 4 words sent. With CAC_WB_PAR_REGEN_EN, word 1 goes out with correct parity; without it, the bad bit goes out. Next wb_req_h clears the flag.
- wb_req_h pulsed during XMIT -> ignored; reset_l low after 2nd ack -> all outputs 0 immediately; a new req after reset runs a full clean transfer.
